// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, reply bytes and FSM state type for the UART command controller.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] OP_PING = 8'h50;

  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_DATA_H,
    ST_DATA_L,
    ST_BUS,
    ST_RESP
  } state_e;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream and memory-bus signals of the command controller.
// master is the controller side, slave is the UART/memory side.
interface uart_cmd_ctrl_if #(
  parameter int unsigned AW = 15
);
  logic          rx_vld;
  logic [7:0]    rx_dat;
  logic          tx_vld;
  logic [7:0]    tx_dat;
  logic          tx_rdy;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdat;
  logic          mem_ack;
  logic [15:0]   mem_rdat;
  logic          err;

  modport master (
    input  rx_vld, rx_dat, tx_rdy, mem_ack, mem_rdat,
    output tx_vld, tx_dat, mem_req, mem_we, mem_addr, mem_wdat, err
  );

  modport slave (
    output rx_vld, rx_dat, tx_rdy, mem_ack, mem_rdat,
    input  tx_vld, tx_dat, mem_req, mem_we, mem_addr, mem_wdat, err
  );
endinterface

// File: rtl/uart_resp_ser.sv
// One- or two-byte response buffer drained over a valid/ready byte port.
module uart_resp_ser (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load_i,
  input  logic [7:0] byte0_i,
  input  logic [7:0] byte1_i,
  input  logic [1:0] cnt_i,
  input  logic       tx_rdy_i,
  output logic       tx_vld_o,
  output logic [7:0] tx_dat_o,
  output logic       busy_o
);

  logic       vld_q, vld_d;
  logic [7:0] dat_q, dat_d;
  logic [7:0] nxt_q, nxt_d;
  logic       more_q, more_d;

  always_comb begin
    vld_d  = vld_q;
    dat_d  = dat_q;
    nxt_d  = nxt_q;
    more_d = more_q;
    if (load_i) begin
      vld_d  = 1'b1;
      dat_d  = byte0_i;
      nxt_d  = byte1_i;
      more_d = (cnt_i == 2'd2);
    end else if (vld_q && tx_rdy_i) begin
      if (more_q) begin
        dat_d  = nxt_q;
        more_d = 1'b0;
      end else begin
        vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q  <= 1'b0;
      dat_q  <= 8'h00;
      nxt_q  <= 8'h00;
      more_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      dat_q  <= dat_d;
      nxt_q  <= nxt_d;
      more_q <= more_d;
    end
  end

  // busy drops during the final handshake so the controller can leave RESP on that same edge
  assign busy_o   = vld_q && !(tx_rdy_i && !more_q);
  assign tx_vld_o = vld_q;
  assign tx_dat_o = dat_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses W/R/P command packets from UART bytes, performs one 16-bit bus access
// per packet and streams ACK/NAK/read data back towards the transmitter.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned AW        = 15,
  parameter int unsigned TO_CYCLES = 100000,
  parameter int unsigned TOW       = 17
) (
  input logic             clk,
  input logic             rstn,
  uart_cmd_ctrl_if.master bus
);

  localparam logic [TOW-1:0] TO_LAST = TOW'(TO_CYCLES - 1);

  state_e         state_q, state_d;
  logic           op_wr_q, op_wr_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [15:0]    data_q, data_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic           mem_req_q, mem_req_d;
  logic           err_q, err_d;

  logic       rx_vld;
  logic [7:0] rx_dat;
  logic       in_pkt, expire, is_cmd;
  logic       ld;
  logic [7:0] ld_b0, ld_b1;
  logic [1:0] ld_cnt;
  logic       ser_vld, ser_busy;
  logic [7:0] ser_dat;

  assign rx_vld = bus.rx_vld;
  assign rx_dat = bus.rx_dat;
  assign is_cmd = (rx_dat == OP_WR) || (rx_dat == OP_RD);
  assign in_pkt = (state_q == ST_ADDR_H) || (state_q == ST_ADDR_L) ||
                  (state_q == ST_DATA_H) || (state_q == ST_DATA_L);
  // a byte arriving in the expiry cycle takes priority over the timeout
  assign expire = in_pkt && !rx_vld && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (rx_vld) state_d = is_cmd ? ST_ADDR_H : ST_RESP;
      ST_ADDR_H: if (rx_vld) state_d = ST_ADDR_L;
                 else if (expire) state_d = ST_IDLE;
      ST_ADDR_L: if (rx_vld) state_d = op_wr_q ? ST_DATA_H : ST_BUS;
                 else if (expire) state_d = ST_IDLE;
      ST_DATA_H: if (rx_vld) state_d = ST_DATA_L;
                 else if (expire) state_d = ST_IDLE;
      ST_DATA_L: if (rx_vld) state_d = ST_BUS;
                 else if (expire) state_d = ST_IDLE;
      ST_BUS:    if (bus.mem_ack) state_d = ST_RESP;
      ST_RESP:   if (!ser_busy) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ld     = 1'b0;
    ld_b0  = RSP_ACK;
    ld_b1  = 8'h00;
    ld_cnt = 2'd1;
    err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_vld && !is_cmd) begin
          ld    = 1'b1;
          ld_b0 = (rx_dat == OP_PING) ? RSP_ACK : RSP_NAK;
          err_d = (rx_dat != OP_PING);
        end
      end
      ST_ADDR_H, ST_ADDR_L, ST_DATA_H, ST_DATA_L: err_d = expire;
      ST_BUS: begin
        err_d = rx_vld;
        if (bus.mem_ack) begin
          ld = 1'b1;
          if (!op_wr_q) begin
            ld_b0  = bus.mem_rdat[15:8];
            ld_b1  = bus.mem_rdat[7:0];
            ld_cnt = 2'd2;
          end
        end
      end
      ST_RESP: err_d = rx_vld;
      default: err_d = 1'b0;
    endcase
    mem_req_d = (state_d == ST_BUS);
  end

  // addr_q holds only AW bits; the shift naturally discards the high address bits
  always_comb begin
    op_wr_d  = op_wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    to_cnt_d = '0;
    if (in_pkt && !rx_vld && !expire) to_cnt_d = to_cnt_q + 1'b1;
    if (rx_vld) begin
      case (state_q)
        ST_IDLE:              if (is_cmd) op_wr_d = (rx_dat == OP_WR);
        ST_ADDR_H, ST_ADDR_L: addr_d = AW'({addr_q, rx_dat});
        ST_DATA_H, ST_DATA_L: data_d = {data_q[7:0], rx_dat};
        default:              op_wr_d = op_wr_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= 16'h0000;
      to_cnt_q  <= '0;
      mem_req_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      to_cnt_q  <= to_cnt_d;
      mem_req_q <= mem_req_d;
      err_q     <= err_d;
    end
  end

  uart_resp_ser u_ser (
    .clk      (clk),
    .rstn     (rstn),
    .load_i   (ld),
    .byte0_i  (ld_b0),
    .byte1_i  (ld_b1),
    .cnt_i    (ld_cnt),
    .tx_rdy_i (bus.tx_rdy),
    .tx_vld_o (ser_vld),
    .tx_dat_o (ser_dat),
    .busy_o   (ser_busy)
  );

  assign bus.tx_vld   = ser_vld;
  assign bus.tx_dat   = ser_dat;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_we   = op_wr_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdat = data_q;
  assign bus.err      = err_q;

endmodule
